raster_sweep_counter: RTL and testbench
=======================================

Name: raster_sweep_counter

Overview:
- Parametrised successor to the single-axis display counter.
- Sweeps a rectangular (x, y) window over the frame buffer, one coordinate pair per accepted beat.
- Drives the plotter/VGA write path with a valid/ready handshake, pause, abort, one-shot or continuous mode, and a frame counter.
- Sits between the graph control FSM (start/window) and the pixel plot stage (consumes x, y).

Parameters:
X_W, 8, width of x coordinate
Y_W, 7, width of y coordinate
FC_W, 8, width of frame counter (wraps)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  terminate sweep immediately
enable  in  1  1 = run, 0 = pause (hold position, no valid)
continuous  in  1  1 = restart window after last beat
x_start  in  X_W  window left edge, latched on accepted start
x_end  in  X_W  window right edge, inclusive
y_start  in  Y_W  window top edge
y_end  in  Y_W  window bottom edge, inclusive
ready  in  1  downstream accepts beat this cycle
x  out  X_W  current x coordinate
y  out  Y_W  current y coordinate
valid  out  1  x/y is a beat: (state==RUN) && enable
first  out  1  valid && x==x_start && y==y_start
last  out  1  valid && x==x_end && y==y_end
busy  out  1  state==RUN
done  out  1  one-cycle registered pulse after window completion
err  out  1  sticky: last start had an inverted window; cleared by next accepted start
frame_count  out  FC_W  completed frames since reset

Behaviour:
- Clock and reset: reset is synchronous, active-low; clock is clk. Reset beats abort, which beats start.
- Reset values: state=IDLE, x=0, y=0, done=0, err=0, frame_count=0, latched window=0. Combinational outputs (valid, first, last, busy) are therefore 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch window and continuous.
  - Window invalid (x_start>x_end or y_start>y_end): err<=1, go to DONE; x and y are unchanged and no beat is issued.
  - Window valid: err<=0, x<=x_start, y<=y_start, go to RUN.
  - Latency: start in cycle N gives first possible valid in cycle N+1.
- RUN, accept = valid && ready:
  - Advance only on accept. Hold x and y on ready=0 or enable=0. valid drops on enable=0 and does not require ready.
  - Advance rule: if x!=x_end, x<=x+1. Else x<=x_start and y<=y+1.
  - Last beat accepted (x==x_end && y==y_end):
    - frame_count<=frame_count+1, modulo 2^FC_W.
    - Latched continuous=1: x<=x_start, y<=y_start, stay in RUN, done<=1 for the next cycle.
    - Latched continuous=0: go to DONE.
  - start is ignored in RUN. Window inputs are ignored except on an accepted start.
- DONE: done=1 for exactly one cycle, then IDLE. x and y hold their last values.
- abort=1 in any state:
  - Next state is IDLE; done<=0; x, y, and frame_count hold.
  - The beat presented in the abort cycle still counts if accepted, but does not complete a frame.
- Single-pixel window (x_start==x_end, y_start==y_end): first and last are asserted together. One beat is issued, then DONE.
- Beat count per frame is (x_end-x_start+1)*(y_end-y_start+1). No x or y overflow is possible because edges are inclusive and compared by equality.
- Reset mid-sweep returns to reset values on the next edge. No done pulse is issued.

Decomposition:
- Shared package raster_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Default geometry constants FB_WIDTH=160, FB_HEIGHT=120.
  - Default X_W and Y_W.
- One sub-module, sweep_axis_counter:
  - Parameter W.
  - Ports: load, load_val, end_val, step, wrap, value.
  - Instantiated twice. The x wrap output drives the y step.

Test Plan:
- Window x 2..3, y 5..6, ready=1, enable=1, one-shot -> beats (2,5),(3,5),(2,6),(3,6); first on beat 1, last on beat 4; done exactly 1 cycle later; frame_count=1.
- Same window, ready toggling 1,0,0,1 -> x/y hold during ready=0; still 4 accepted beats; no coordinate skipped or repeated.
- enable=0 for 3 cycles mid-frame at (3,5) -> valid=0, x/y stay (3,5); resume at (3,5).
- continuous=1, window 0..1 x 0..0, 3 frames -> beats (0,0),(1,0) repeated; done pulse each frame concurrent with next (0,0); frame_count=3; busy stays 1.
- start with x_start=9, x_end=4 -> err=1, done pulse, zero valid beats. Next valid start -> err=0.
- abort at beat 2 of 4, and separately reset low at beat 2 -> IDLE next cycle; no done; frame_count unchanged (abort) or 0 (reset).

Source files
------------

// File: rtl/raster_pkg.sv
// Shared definitions for the raster sweep counter.
// Holds the sweep FSM state type and default frame-buffer geometry.
package raster_pkg;

  // Default frame-buffer geometry; the coordinate widths below cover it.
  localparam int unsigned FB_WIDTH    = 160;
  localparam int unsigned FB_HEIGHT   = 120;
  localparam int unsigned DEFAULT_X_W = 8;
  localparam int unsigned DEFAULT_Y_W = 7;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/sweep_axis_counter.sv
// One axis of the raster sweep.
// Ports:
//   clk, reset  clock and synchronous active-low reset (value -> 0)
//   load        force value to load_val (takes priority over step)
//   load_val    start edge of the window
//   end_val     inclusive end edge of the window
//   step        advance one position; wraps to load_val from end_val
//   wrap        value sits at end_val, so the next step reloads load_val
//   value       current coordinate
module sweep_axis_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] end_val,
  input  logic         step,
  output logic         wrap,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // Equality compare against an inclusive edge: the counter can never pass end_val.
  assign wrap  = (value_q == end_val);
  assign value = value_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (step) begin
      value_q <= wrap ? load_val : value_q + W'(1);
    end
  end

endmodule

// File: rtl/raster_sweep_counter.sv
// Raster sweep counter: walks an inclusive (x, y) window one coordinate per accepted beat,
// x fastest, with pause, abort, one-shot/continuous mode and a wrapping frame counter.
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   start, abort, enable          control (start sampled only in idle; abort wins over start)
//   continuous                    restart window after the last beat (latched on start)
//   x_start/x_end/y_start/y_end   window, latched on an accepted start
//   ready                         downstream accepts the beat this cycle
//   x, y                          current coordinate
//   valid, first, last, busy      combinational beat/status flags
//   done                          one-cycle pulse after a window completes
//   err                           sticky inverted-window flag, cleared by next accepted start
//   frame_count                   completed frames since reset (wraps)
module raster_sweep_counter
  import raster_pkg::*;
#(
  parameter int unsigned X_W  = DEFAULT_X_W,
  parameter int unsigned Y_W  = DEFAULT_Y_W,
  parameter int unsigned FC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            enable,
  input  logic            continuous,
  input  logic [X_W-1:0]  x_start,
  input  logic [X_W-1:0]  x_end,
  input  logic [Y_W-1:0]  y_start,
  input  logic [Y_W-1:0]  y_end,
  input  logic            ready,
  output logic [X_W-1:0]  x,
  output logic [Y_W-1:0]  y,
  output logic            valid,
  output logic            first,
  output logic            last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [FC_W-1:0] frame_count
);

  sweep_state_e state_q, state_d;

  logic [X_W-1:0]  xs_q, xe_q;
  logic [Y_W-1:0]  ys_q, ye_q;
  logic            cont_q;
  logic            err_q;
  logic            done_q, done_d;
  logic [FC_W-1:0] fc_q;

  logic            win_ok, start_acc, accept, frame_end;
  logic            load, x_step, y_step, x_wrap, y_wrap;
  logic [X_W-1:0]  x_load_val;
  logic [Y_W-1:0]  y_load_val;

  assign win_ok    = (x_start <= x_end) && (y_start <= y_end);
  assign start_acc = (state_q == StIdle) && start && !abort;
  assign accept    = valid && ready;
  // The abort-cycle beat may be taken downstream but never completes a frame.
  assign frame_end = accept && x_wrap && y_wrap && !abort;

  assign load   = start_acc && win_ok;
  // A one-shot window parks on its last coordinate instead of wrapping.
  assign x_step = accept && !abort && !(frame_end && !cont_q);
  assign y_step = x_step && x_wrap;

  // Load from the live inputs on start; later wraps reload from the latched edges.
  assign x_load_val = (state_q == StIdle) ? x_start : xs_q;
  assign y_load_val = (state_q == StIdle) ? y_start : ys_q;

  sweep_axis_counter #(
    .W (X_W)
  ) u_x_axis (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (x_load_val),
    .end_val  (xe_q),
    .step     (x_step),
    .wrap     (x_wrap),
    .value    (x)
  );

  sweep_axis_counter #(
    .W (Y_W)
  ) u_y_axis (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (y_load_val),
    .end_val  (ye_q),
    .step     (y_step),
    .wrap     (y_wrap),
    .value    (y)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_acc) begin
          state_d = win_ok ? StRun : StDone;
          done_d  = !win_ok;
        end
      end
      StRun: begin
        if (frame_end) begin
          done_d = 1'b1;
          if (!cont_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fc_q    <= '0;
      cont_q  <= 1'b0;
      xs_q    <= '0;
      xe_q    <= '0;
      ys_q    <= '0;
      ye_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        xs_q   <= x_start;
        xe_q   <= x_end;
        ys_q   <= y_start;
        ye_q   <= y_end;
        cont_q <= continuous;
        err_q  <= !win_ok;
      end
      if (frame_end) fc_q <= fc_q + FC_W'(1);
    end
  end

  assign busy        = (state_q == StRun);
  assign valid       = busy && enable;
  assign first       = valid && (x == xs_q) && (y == ys_q);
  assign last        = valid && x_wrap && y_wrap;
  assign done        = done_q;
  assign err         = err_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_raster_sweep_counter.sv
// Self-checking bench for raster_sweep_counter: directed scenarios plus randomized sweeps,
// compared every cycle against a window/beat-list reference model.
module tb_raster_sweep_counter;

  localparam int unsigned X_W  = 8;
  localparam int unsigned Y_W  = 7;
  localparam int unsigned FC_W = 8;

  logic            clk = 1'b0;
  logic            reset, start, abort, enable, continuous, ready;
  logic [X_W-1:0]  x_start, x_end;
  logic [Y_W-1:0]  y_start, y_end;
  logic [X_W-1:0]  x;
  logic [Y_W-1:0]  y;
  logic            valid, first, last, busy, done, err;
  logic [FC_W-1:0] frame_count;

  raster_sweep_counter #(
    .X_W  (X_W),
    .Y_W  (Y_W),
    .FC_W (FC_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .enable      (enable),
    .continuous  (continuous),
    .x_start     (x_start),
    .x_end       (x_end),
    .y_start     (y_start),
    .y_end       (y_end),
    .ready       (ready),
    .x           (x),
    .y           (y),
    .valid       (valid),
    .first       (first),
    .last        (last),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: a phase, the ordered list of window coordinates, and a position in it.
  int m_phase;  // 0 idle, 1 sweeping, 2 completion cycle
  int m_idx;
  int m_x, m_y, m_fc;
  bit m_done, m_err, m_cont;
  int seq_x[$];
  int seq_y[$];
  int got_x[$];
  int got_y[$];

  int exp_x[4] = '{2, 3, 2, 3};
  int exp_y[4] = '{5, 5, 6, 6};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_idx   = 0;
    m_x     = 0;
    m_y     = 0;
    m_fc    = 0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_cont  = 1'b0;
    seq_x.delete();
    seq_y.delete();
  endtask

  // Compare every output mid-cycle, then advance the model with this cycle's inputs.
  task automatic step();
    bit ev, nd;
    int last_i;
    @(negedge clk);
    ev     = (m_phase == 1) && enable;
    last_i = seq_x.size() - 1;
    check("x", 32'(x), 32'(m_x));
    check("y", 32'(y), 32'(m_y));
    check("valid", 32'(valid), 32'(ev));
    check("first", 32'(first), 32'(ev && m_idx == 0));
    check("last", 32'(last), 32'(ev && m_idx == last_i));
    check("busy", 32'(busy), 32'(m_phase == 1));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    check("frame_count", 32'(frame_count), 32'(m_fc));
    if (valid && ready) begin
      got_x.push_back(int'(x));
      got_y.push_back(int'(y));
    end
    nd = 1'b0;
    if (!reset) begin
      model_reset();
    end else if (abort) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: begin
          if (start) begin
            m_cont = continuous;
            if (x_start > x_end || y_start > y_end) begin
              m_err   = 1'b1;
              m_phase = 2;
              nd      = 1'b1;
            end else begin
              m_err = 1'b0;
              seq_x.delete();
              seq_y.delete();
              for (int yy = int'(y_start); yy <= int'(y_end); yy++) begin
                for (int xx = int'(x_start); xx <= int'(x_end); xx++) begin
                  seq_x.push_back(xx);
                  seq_y.push_back(yy);
                end
              end
              m_idx   = 0;
              m_phase = 1;
              m_x     = seq_x[0];
              m_y     = seq_y[0];
            end
          end
        end
        1: begin
          if (enable && ready) begin
            if (m_idx == last_i) begin
              m_fc = (m_fc + 1) % (1 << FC_W);
              nd   = 1'b1;
              if (m_cont) m_idx = 0;
              else m_phase = 2;
            end else begin
              m_idx++;
            end
            m_x = seq_x[m_idx];
            m_y = seq_y[m_idx];
          end
        end
        default: m_phase = 0;
      endcase
    end
    m_done = nd;
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int xs, input int xe, input int ys, input int ye, input bit c);
    x_start    = X_W'(xs);
    x_end      = X_W'(xe);
    y_start    = Y_W'(ys);
    y_end      = Y_W'(ye);
    continuous = c;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_trace(input string tag);
    check({tag, "_beats"}, 32'(got_x.size()), 32'd4);
    for (int i = 0; i < got_x.size() && i < 4; i++) begin
      check($sformatf("%s_x%0d", tag, i), 32'(got_x[i]), 32'(exp_x[i]));
      check($sformatf("%s_y%0d", tag, i), 32'(got_y[i]), 32'(exp_y[i]));
    end
  endtask

  int rx, ry, rw, rh;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; enable = 1'b1; ready = 1'b1;
    set_win(0, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    step();  // reset held: all outputs at reset values
    reset = 1'b1;
    step();

    // One-shot 2x2 window, full throughput
    got_x.delete(); got_y.delete();
    set_win(2, 3, 5, 6, 1'b0);
    do_start();
    repeat (6) step();
    check_trace("t1");
    check("t1_fc", 32'(frame_count), 32'd1);

    // Same window with ready pattern 1,0,0,1
    got_x.delete(); got_y.delete();
    do_start();
    for (int i = 0; i < 12; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    ready = 1'b1;
    check_trace("t2");
    check("t2_fc", 32'(frame_count), 32'd2);

    // Pause at (3,5)
    got_x.delete(); got_y.delete();
    do_start();
    step();
    enable = 1'b0;
    repeat (3) step();
    check("t3_x_hold", 32'(x), 32'd3);
    check("t3_y_hold", 32'(y), 32'd5);
    check("t3_valid_low", 32'(valid), 32'd0);
    enable = 1'b1;
    repeat (6) step();
    check_trace("t3");
    check("t3_fc", 32'(frame_count), 32'd3);

    // Continuous 2x1 window, three frames, then abort
    set_win(0, 1, 0, 0, 1'b1);
    do_start();
    repeat (6) step();
    check("t4_fc", 32'(frame_count), 32'd6);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_done", 32'(done), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check("t4_idle", 32'(busy), 32'd0);

    // Inverted window, then a single-pixel window
    set_win(9, 4, 0, 0, 1'b0);
    do_start();
    check("t5_err", 32'(err), 32'd1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_no_beat", 32'(valid), 32'd0);
    repeat (2) step();
    set_win(1, 1, 1, 1, 1'b0);
    do_start();
    check("t5_first", 32'(first), 32'd1);
    check("t5_last", 32'(last), 32'd1);
    step();
    check("t5_err_clr", 32'(err), 32'd0);
    check("t5_done1", 32'(done), 32'd1);
    step();

    // Abort at beat 2 of 4
    set_win(2, 3, 5, 6, 1'b0);
    do_start();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_abort_idle", 32'(busy), 32'd0);
    check("t6_abort_x", 32'(x), 32'd3);
    check("t6_abort_fc", 32'(frame_count), 32'd7);
    step();
    check("t6_abort_nodone", 32'(done), 32'd0);

    // Reset at beat 2 of 4
    do_start();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t6_rst_fc", 32'(frame_count), 32'd0);
    check("t6_rst_x", 32'(x), 32'd0);
    step();

    // Randomized sweeps with noisy handshake, stray starts and window changes
    for (int s = 0; s < 25; s++) begin
      rx = $urandom_range(1, 200);
      ry = $urandom_range(1, 100);
      rw = $urandom_range(0, 3);
      rh = $urandom_range(0, 2);
      set_win(rx, rx + rw, ry, ry + rh, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) x_end = X_W'(rx - 1);
      do_start();
      for (int c = 0; c < 60 && m_phase != 0; c++) begin
        ready   = $urandom_range(0, 9) < 7;
        enable  = $urandom_range(0, 9) < 8;
        abort   = (c == 40) || ($urandom_range(0, 49) == 0);
        start   = $urandom_range(0, 7) == 0;
        x_start = X_W'($urandom);
        x_end   = X_W'($urandom);
        y_start = Y_W'($urandom);
        y_end   = Y_W'($urandom);
        step();
      end
      abort = 1'b0; start = 1'b0; ready = 1'b1; enable = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
